// File: rtl/gpio_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the GPIO hex transmitter: FSM states, default
// timing for a 50 MHz clock, and the board pin map used at top level.
package gpio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    GAP    = 2'd3
  } tx_state_e;

  localparam int unsigned DEF_SETUP_CYCLES  = 4;
  localparam int unsigned DEF_STROBE_CYCLES = 10000;
  localparam int unsigned DEF_GAP_CYCLES    = 100;

  // gpio1 connector positions; DATA_PIN[i] carries logical data bit i.
  localparam int unsigned GPIO1_WIDTH = 36;
  localparam int unsigned DATA_PIN [8] = '{27, 26, 29, 28, 31, 30, 33, 32};
  localparam int unsigned STROBE_PIN  = 25;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tx_timer.sv
`timescale 1ns/1ps
// Loadable down-counter; holds at zero and flags done while it is zero.
module tx_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/gpio_hex_tx.sv
`timescale 1ns/1ps
// Sends one byte over parallel GPIO lines framed by a long data-valid strobe:
// data settles, strobe pulses, data is held for a gap, then the block idles.
module gpio_hex_tx
  import gpio_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int unsigned STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] gpio_data,
  output logic       gpio_strobe,
  output logic       busy
);

  localparam int unsigned CNT_W =
    $clog2(max3(SETUP_CYCLES, STROBE_CYCLES, GAP_CYCLES)) + 1;

  tx_state_e   state_q;
  logic [7:0]  hold_q;
  logic        strobe_q;
  logic        busy_q;
  logic        ready_q;

  logic             accept;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_done;

  // ready_q is only ever set in IDLE, so it alone qualifies an accept.
  assign accept = tx_valid && ready_q;

  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          timer_load = 1'b1;
          timer_val  = CNT_W'(SETUP_CYCLES - 1);
        end
      end
      SETUP: begin
        if (timer_done) begin
          timer_load = 1'b1;
          timer_val  = CNT_W'(STROBE_CYCLES - 1);
        end
      end
      STROBE: begin
        if (timer_done) begin
          timer_load = 1'b1;
          timer_val  = CNT_W'(GAP_CYCLES - 1);
        end
      end
      default: begin
        timer_load = 1'b0;
      end
    endcase
  end

  tx_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .done_o     (timer_done)
  );

  // Outputs are updated together with the state so every pin comes from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      hold_q   <= 8'h00;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= SETUP;
            hold_q  <= tx_data;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        SETUP: begin
          if (timer_done) begin
            state_q  <= STROBE;
            strobe_q <= 1'b1;
          end
        end
        STROBE: begin
          if (timer_done) begin
            state_q  <= GAP;
            strobe_q <= 1'b0;
          end
        end
        GAP: begin
          if (timer_done) begin
            state_q <= IDLE;
            hold_q  <= 8'h00;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready    = ready_q;
  assign gpio_data   = hold_q;
  assign gpio_strobe = strobe_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_gpio_hex_tx.sv
`timescale 1ns/1ps
// Self-checking bench for gpio_hex_tx: a short-timing instance against a
// cycle-count reference model, plus a default-timing instance decoded via the pin map.
module tb_gpio_hex_tx;
  import gpio_pkg::*;

  localparam int S     = 2;
  localparam int P     = 5;
  localparam int G     = 3;
  localparam int TOTAL = S + P + G;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] gpio_data;
  logic       gpio_strobe;
  logic       busy;

  logic       clk_def = 1'b0;
  logic       rst_def = 1'b1;
  logic [7:0] def_data = 8'h00;
  logic       def_valid = 1'b0;
  logic       def_ready;
  logic [7:0] def_gpio;
  logic       def_strobe;
  logic       def_busy;
  logic [GPIO1_WIDTH-1:0] gpio1;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles elapsed since accept (0 = idle).
  int         m_phase = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_armed = 1'b0;
  bit         m_acc = 1'b0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always #10 clk_def = ~clk_def;

  gpio_hex_tx #(
    .SETUP_CYCLES  (S),
    .STROBE_CYCLES (P),
    .GAP_CYCLES    (G)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .gpio_data   (gpio_data),
    .gpio_strobe (gpio_strobe),
    .busy        (busy)
  );

  gpio_hex_tx dut_def (
    .clk         (clk_def),
    .rst         (rst_def),
    .tx_data     (def_data),
    .tx_valid    (def_valid),
    .tx_ready    (def_ready),
    .gpio_data   (def_gpio),
    .gpio_strobe (def_strobe),
    .busy        (def_busy)
  );

  // Board-level swizzle onto the gpio1 connector.
  always_comb begin
    gpio1 = '0;
    for (int i = 0; i < 8; i++) gpio1[DATA_PIN[i]] = def_gpio[i];
    gpio1[STROBE_PIN] = def_strobe;
  end

  function automatic logic [7:0] rx_decode(input logic [GPIO1_WIDTH-1:0] bus);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = bus[DATA_PIN[i]];
    return b;
  endfunction

  // Expected {gpio_data, gpio_strobe, busy, tx_ready}.
  function automatic logic [10:0] expected();
    logic [7:0] d;
    logic       s;
    d = (m_phase > 0) ? m_byte : 8'h00;
    s = (m_phase >= S + 1) && (m_phase <= S + P);
    return {d, s, (m_phase > 0), (m_phase == 0) && m_armed};
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    m_acc = 1'b0;
    if (rst) begin
      if (m_phase == 0) begin
        if (m_armed && tx_valid) begin
          m_phase = 1;
          m_byte  = tx_data;
          m_acc   = 1'b1;
        end
      end else if (m_phase == TOTAL) begin
        m_phase = 0;
      end else begin
        m_phase++;
      end
      m_armed = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    rst = 1'b0;
    rst_def = 1'b0;
    #1;
    checks++;
    if ({gpio_data, gpio_strobe, busy, tx_ready} !== 11'h000) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h", {gpio_data, gpio_strobe, busy, tx_ready}, 11'h000);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({gpio_data, gpio_strobe, busy, tx_ready} !== 11'h000) begin
      errors++;
      $display("FAIL reset_clocked: got %h expected %h", {gpio_data, gpio_strobe, busy, tx_ready}, 11'h000);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 0", tx_ready);
    end
    @(negedge clk);
    tick();
    checks++;
    if ({gpio_data, gpio_strobe, busy, tx_ready} !== expected()) begin
      errors++;
      $display("FAIL reset_first_edge: got %h expected %h", {gpio_data, gpio_strobe, busy, tx_ready}, expected());
    end
  endtask

  task automatic test_single_send();
    int rises = 0;
    logic prev = 1'b0;
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      checks++;
      if ({gpio_data, gpio_strobe, busy, tx_ready} !== expected()) begin
        errors++;
        $display("FAIL single_send cyc %0d: got %h expected %h", k, {gpio_data, gpio_strobe, busy, tx_ready}, expected());
      end
      if (gpio_strobe && !prev) rises++;
      prev = gpio_strobe;
      tx_data = 8'($urandom);
      tick();
    end
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL single_send_rises: got %0d expected 1", rises);
    end
  endtask

  task automatic test_data_change();
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      checks++;
      if ({gpio_data, gpio_strobe, busy, tx_ready} !== expected()) begin
        errors++;
        $display("FAIL data_change cyc %0d: got %h expected %h", k, {gpio_data, gpio_strobe, busy, tx_ready}, expected());
      end
      if (m_phase == S + 2) tx_data = 8'h55;
      tx_valid = (m_phase == S + P + 1);
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    int rise_cyc[$];
    logic prev = 1'b0;
    q = '{8'h12, 8'hAB};
    tx_data  = q[0];
    tx_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      checks++;
      if ({gpio_data, gpio_strobe, busy, tx_ready} !== expected()) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: got %h expected %h", k, {gpio_data, gpio_strobe, busy, tx_ready}, expected());
      end
      if (gpio_strobe && !prev) rise_cyc.push_back(cyc);
      prev = gpio_strobe;
      tick();
      if (m_acc) begin
        void'(q.pop_front());
        if (q.size() == 0) tx_valid = 1'b0;
        else tx_data = q[0];
      end
    end
    checks++;
    if (rise_cyc.size() != 2) begin
      errors++;
      $display("FAIL back_to_back_count: got %0d expected 2", rise_cyc.size());
    end else begin
      checks++;
      if (rise_cyc[1] - rise_cyc[0] != TOTAL + 1) begin
        errors++;
        $display("FAIL back_to_back_period: got %0d expected %0d", rise_cyc[1] - rise_cyc[0], TOTAL + 1);
      end
    end
  endtask

  task automatic test_random();
    bit pending = 1'b0;
    for (int k = 0; k < 300; k++) begin
      checks++;
      if ({gpio_data, gpio_strobe, busy, tx_ready} !== expected()) begin
        errors++;
        $display("FAIL random cyc %0d: got %h expected %h", k, {gpio_data, gpio_strobe, busy, tx_ready}, expected());
      end
      if (!pending) begin
        tx_data = 8'($urandom);
        if ($urandom_range(0, 2) == 0) begin
          pending  = 1'b1;
          tx_valid = 1'b1;
        end else begin
          tx_valid = 1'b0;
        end
      end
      tick();
      if (m_acc) begin
        pending  = 1'b0;
        tx_valid = 1'b0;
      end
    end
    tx_valid = 1'b0;
    for (int k = 0; k < 20 && m_phase != 0; k++) tick();
  endtask

  task automatic test_reset_mid_strobe();
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int k = 0; k < 20 && m_phase != S + 4; k++) tick();
    checks++;
    if ({gpio_data, gpio_strobe} !== {8'h96, 1'b1}) begin
      errors++;
      $display("FAIL mid_strobe_pre: got %h expected %h", {gpio_data, gpio_strobe}, {8'h96, 1'b1});
    end
    #2;
    rst = 1'b0;
    m_phase = 0;
    m_armed = 1'b0;
    #1;
    checks++;
    if ({gpio_data, gpio_strobe, busy, tx_ready} !== 11'h000) begin
      errors++;
      $display("FAIL mid_strobe_abort: got %h expected %h", {gpio_data, gpio_strobe, busy, tx_ready}, 11'h000);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_strobe_release_ready: got %b expected 0", tx_ready);
    end
    for (int k = 0; k < 15; k++) begin
      tick();
      checks++;
      if ({gpio_data, gpio_strobe, busy, tx_ready} !== expected()) begin
        errors++;
        $display("FAIL mid_strobe_after cyc %0d: got %h expected %h", k, {gpio_data, gpio_strobe, busy, tx_ready}, expected());
      end
    end
  endtask

  task automatic test_defaults();
    longint t_rise = -1, t_fall = -1, t_clear = -1;
    logic [7:0] rx_byte = 8'h00;
    logic prev = 1'b0;
    @(negedge clk_def);
    rst_def = 1'b1;
    @(negedge clk_def);
    def_data  = 8'hC3;
    def_valid = 1'b1;
    @(negedge clk_def);
    def_valid = 1'b0;
    def_data  = 8'h00;
    for (int k = 0; k < 12000 && t_clear < 0; k++) begin
      @(negedge clk_def);
      if (gpio1[STROBE_PIN] && !prev) begin
        t_rise  = $time;
        rx_byte = rx_decode(gpio1);
      end
      if (!gpio1[STROBE_PIN] && prev) t_fall = $time;
      if (t_fall >= 0 && rx_decode(gpio1) == 8'h00) t_clear = $time;
      prev = gpio1[STROBE_PIN];
    end
    checks++;
    if (t_clear < 0 || t_rise < 0) begin
      errors++;
      $display("FAIL defaults_timeout: rise %0d fall %0d clear %0d", t_rise, t_fall, t_clear);
    end else begin
      checks++;
      if (t_fall - t_rise != 200000) begin
        errors++;
        $display("FAIL defaults_strobe_ns: got %0d expected 200000", t_fall - t_rise);
      end
      checks++;
      if (t_clear - t_fall != 2000) begin
        errors++;
        $display("FAIL defaults_hold_ns: got %0d expected 2000", t_clear - t_fall);
      end
      checks++;
      if (rx_byte !== 8'hC3) begin
        errors++;
        $display("FAIL defaults_decode: got %h expected c3", rx_byte);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_send();
    test_data_change();
    test_back_to_back();
    test_random();
    test_reset_mid_strobe();
    test_defaults();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_hex_tx.md
GPIO_HEX_TX -- requirements
Module: gpio_hex_tx

Interface
REQ-001 Parameter SETUP_CYCLES, default 4: cycles data lines are stable before strobe rises (legal range >= 1).
REQ-002 Parameter STROBE_CYCLES, default 10000: strobe high time in cycles, 200 us at 50 MHz (legal range >= 1).
REQ-003 Parameter GAP_CYCLES, default 100: cycles data is held after strobe falls, 2 us at 50 MHz (legal range >= 1).
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 tx_data  input  8  byte to send; sampled only on an accept.
REQ-007 tx_valid  input  1  requester has a byte on tx_data.
REQ-008 tx_ready  output  1  block can accept a byte this cycle.
REQ-009 gpio_data  output  8  parallel data lines, logical bit order, bit 7 = MSB.
REQ-010 gpio_strobe  output  1  data-valid strobe to the receiving board.
REQ-011 busy  output  1  a transfer is in progress (any state other than IDLE).

Function
REQ-012 States SHALL be IDLE, SETUP, STROBE and GAP; every output SHALL be a registered function of the state and the latched byte.
REQ-013 tx_ready SHALL be 1 only in IDLE; an accept SHALL occur on a rising edge where tx_valid=1 and tx_ready=1.
REQ-014 On accept: latch tx_data into a hold register, drive gpio_data from it, enter SETUP, load the counter with SETUP_CYCLES-1.
REQ-015 Later changes on tx_data SHALL NOT affect gpio_data until the next accept.
REQ-016 SETUP SHALL last exactly SETUP_CYCLES cycles, with gpio_strobe=0, then enter STROBE.
REQ-017 STROBE SHALL last exactly STROBE_CYCLES cycles, with gpio_strobe=1, then enter GAP.
REQ-018 GAP SHALL last exactly GAP_CYCLES cycles, with gpio_strobe=0, then enter IDLE.
REQ-019 gpio_data SHALL equal the latched byte from SETUP through GAP, and SHALL be 0x00 in IDLE.
REQ-020 tx_valid SHALL be ignored in SETUP, STROBE and GAP; a byte is never queued or dropped silently, because the requester holds tx_valid until it is accepted.
REQ-021 Back-to-back transfers: at least one IDLE cycle separates GAP and the next SETUP, so the minimum period is SETUP+STROBE+GAP+1 cycles.
REQ-022 Counter width SHALL be $clog2 of the largest parameter plus 1; it counts down and reloads on each state entry, with no wrap-around in any state.
REQ-023 The strobe SHALL be glitch-free: driven directly from a flop, with exactly one rising and one falling edge per transfer.

Reset
REQ-024 While rst=0, regardless of clock: state=IDLE, counter=0, hold register=0x00, gpio_data=0x00, gpio_strobe=0, busy=0, tx_ready=0.
REQ-025 tx_ready SHALL become 1 on the first rising edge after rst deasserts.
REQ-026 Reset during any transfer SHALL abort it immediately; strobe drops with no completion, and the byte is not retried.

Structure
REQ-027 A shared package gpio_pkg SHALL hold:
- the state enum;
- the default timing constants (SETUP/STROBE/GAP);
- the board pin map, logical bit 7..0 -> gpio1[32],[33],[30],[31],[28],[29],[26],[27], strobe -> gpio1[25].
REQ-028 Pin swizzling SHALL happen at top level, never inside this block.
REQ-029 One sub-module, tx_timer (loadable down-counter with a done flag), SHALL provide all interval timing.

Verification
Benches use SETUP_CYCLES=2, STROBE_CYCLES=5, GAP_CYCLES=3 unless stated.
REQ-030 Single send:
- Stimulus: tx_data=0xC3, tx_valid=1 for one cycle from IDLE.
- Response: gpio_data=0xC3 for 10 cycles; gpio_strobe high exactly in cycles 3-7 after accept; then IDLE with gpio_data=0x00 and tx_ready=1.
REQ-031 Back-to-back:
- Stimulus: tx_valid held high with 0x12 then 0xAB.
- Response: two strobes 11 cycles apart edge-to-edge; each byte stable across its whole strobe.
REQ-032 Data change and ignored valid:
- Stimulus: tx_data toggles to 0x55 mid-STROBE; tx_valid pulses during GAP.
- Response: gpio_data stays 0xC3; no extra transfer occurs.
REQ-033 Reset mid-strobe:
- Stimulus: rst=0 at cycle 4 of STROBE, asynchronous to clk.
- Response: gpio_strobe and gpio_data go to 0 within the same timestep; tx_ready=1 one edge after rst=1.
REQ-034 Defaults:
- Stimulus: default parameters at 50 MHz, byte 0xC3.
- Response: strobe high 200000 ns, data held 2000 ns after strobe falls; a gpio receiver model at top level decodes 0xC3.
